dmem_reg_ctrl: RTL and testbench
================================

DMEM_REG_CTRL -- requirements
Module: dmem_reg_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the width of data words in memory and registers.
REQ-002 Parameter ADDR_W, default 8, SHALL set the data-memory address width; memory depth SHALL be 2**ADDR_W words.
REQ-003 Parameter REG_AW, default 5, SHALL set the register address width; register count SHALL be 2**REG_AW.
REQ-004 The module SHALL use one clock and a synchronous, active-low reset, with ports clk and rst_n.
REQ-005 Ports SHALL be:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- op_valid  in  1  memory operation request
- op_ready  out  1  controller can accept an operation
- op_kind  in  1  0 = load (mem->reg), 1 = store (reg->mem)
- op_maddr  in  ADDR_W  memory word address
- op_reg  in  REG_AW  load destination / store source register
- done  out  1  one-cycle completion pulse
- ext_we  in  1  external register write, e.g. ALU writeback
- ext_waddr  in  REG_AW  external write address
- ext_wdata  in  DATA_W  external write data
- ext_ready  out  1  external write port available
- ra_addr, rb_addr  in  REG_AW  read addresses
- ra_data, rb_data  out  DATA_W  read data

Function
REQ-006 Internal storage SHALL be a synchronous-read, synchronous-write data memory (1-cycle read latency) and a register file (combinational read, synchronous write).
REQ-007 The FSM SHALL have the states IDLE, LD_RD, LD_WB and ST_WR.
REQ-008 op_ready SHALL be 1 only in IDLE; an operation is accepted on a rising edge with op_valid=1 and op_ready=1, capturing op_kind, op_maddr and op_reg.
REQ-009 On accept, the FSM SHALL go IDLE->LD_RD for a load and IDLE->ST_WR for a store; op_valid SHALL be ignored outside IDLE.
REQ-010 In LD_RD, memory SHALL be read at the captured address, and the FSM SHALL go to LD_WB.
REQ-011 In LD_WB, the memory output SHALL be written to the captured register at cycle end, done=1, and the FSM SHALL go to IDLE; load accept-to-IDLE SHALL take 3 cycles.
REQ-012 In ST_WR, register[captured op_reg] SHALL be written to memory at cycle end, done=1, and the FSM SHALL go to IDLE; store accept-to-IDLE SHALL take 2 cycles.
REQ-013 done SHALL be 0 in every other state; back-to-back operations SHALL be allowed, with the next accept on the first IDLE cycle.
REQ-014 ext_ready SHALL be 0 in LD_WB and 1 otherwise; ext_we with ext_ready=0 SHALL be ignored, and the requester holds it.
REQ-015 An ext_we with ext_ready=1 SHALL write ext_wdata to ext_waddr at cycle end.
REQ-016 When an ext write to register R and an ST_WR reading R occur in the same cycle, the store SHALL use R's pre-write value.
REQ-017 ra_data and rb_data SHALL be combinational register reads with no write bypass; a write SHALL be visible the cycle after its edge, and ra_addr=rb_addr SHALL return identical data.
REQ-018 Addresses SHALL cover the full range with no out-of-range case; 2**ADDR_W-1 and 0 SHALL be independent words.
REQ-019 Data SHALL be transferred unmodified at DATA_W bits, with no sign extension or truncation.

Reset
REQ-020 With rst_n=0 at a rising edge, the FSM SHALL enter IDLE, done=0, and all registers SHALL clear to 0; memory contents SHALL be preserved.
REQ-021 After reset, op_ready=1 and ext_ready=1.
REQ-022 Reset in LD_RD or LD_WB SHALL abort the load with no register write; reset in ST_WR SHALL abort with no memory write.
REQ-023 Accepts and ext writes SHALL be ignored while rst_n=0.

Verification
REQ-024 Write R3=0x1234 via ext, store R3->mem[0x10], load mem[0x10]->R7 -> done pulses 2 and 3 cycles after the accepts; ra_addr=7 reads 0x1234.
REQ-025 Load to R5 with ext_we to R9 during LD_WB -> ext_ready=0 in that cycle, R9 is written only once the request is held into the next cycle, and R5 holds the loaded value.
REQ-026 Store from R2 (0x00AA) with a same-cycle ext write R2=0x5555 in ST_WR -> memory holds 0x00AA and R2 reads 0x5555 next cycle.
REQ-027 Store 0xBEEF to mem[0xFF] and 0x0001 to mem[0x00], then load both -> each value returns unaliased.
REQ-028 Reset asserted during LD_WB of a load to R4 -> R4=0, done stays 0, and op_ready=1 after reset.
REQ-029 op_valid held high for 3 consecutive stores -> accepts occur every 2 cycles, with exactly 3 done pulses.

Source files
------------

// File: rtl/dmem_reg_ctrl.sv
`timescale 1ns/1ps
// dmem_reg_ctrl: data memory plus register file with a load/store sequencer.
// Latency: load accept->IDLE 3 cycles (done in LD_WB), store accept->IDLE
// 2 cycles (done in ST_WR).
// Backpressure: op_ready only in IDLE; ext_ready drops in LD_WB, where the
// register write port belongs to the load, and the requester must hold ext_we.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   op_valid/op_ready          operation handshake
//   op_kind                    0 = load (mem->reg), 1 = store (reg->mem)
//   op_maddr, op_reg           memory word address, register index
//   done                       one-cycle completion pulse
//   ext_we/ext_waddr/ext_wdata external register write (e.g. ALU writeback)
//   ext_ready                  external write port available
//   ra_addr/ra_data, rb_addr/rb_data  combinational register read ports
module dmem_reg_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_kind,
  input  logic [ADDR_W-1:0] op_maddr,
  input  logic [REG_AW-1:0] op_reg,
  output logic              done,
  input  logic              ext_we,
  input  logic [REG_AW-1:0] ext_waddr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ready,
  input  logic [REG_AW-1:0] ra_addr,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data
);

  localparam int MEM_DEPTH = 2 ** ADDR_W;
  localparam int NUM_REGS  = 2 ** REG_AW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LD_RD = 2'd1,
    LD_WB = 2'd2,
    ST_WR = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [REG_AW-1:0]   oreg_q, oreg_d;
  logic                done_q, done_d;
  logic                op_ready_q, op_ready_d;
  logic                ext_ready_q, ext_ready_d;

  logic [DATA_W-1:0]   mem_q [MEM_DEPTH];
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_wdata;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic                ext_acc;
  logic                ld_we;

  // ---------------------------------------------------------------------------
  // Sequencer next-state. Outputs are registered, so they are derived from the
  // state being entered rather than the current one.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    maddr_d = maddr_q;
    oreg_d  = oreg_q;
    unique case (state_q)
      IDLE: begin
        if (op_valid) begin
          maddr_d = op_maddr;
          oreg_d  = op_reg;
          state_d = op_kind ? ST_WR : LD_RD;
        end
      end
      LD_RD:   state_d = LD_WB;
      LD_WB:   state_d = IDLE;
      ST_WR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d      = (state_d == LD_WB) || (state_d == ST_WR);
    op_ready_d  = (state_d == IDLE);
    ext_ready_d = (state_d != LD_WB);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      maddr_q     <= '0;
      oreg_q      <= '0;
      done_q      <= 1'b0;
      op_ready_q  <= 1'b1;
      ext_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      maddr_q     <= maddr_d;
      oreg_q      <= oreg_d;
      done_q      <= done_d;
      op_ready_q  <= op_ready_d;
      ext_ready_q <= ext_ready_d;
    end
  end

  // A reset arriving mid-operation aborts it, so the completion pulse of that
  // cycle is withheld too.
  assign done      = done_q & rst_n;
  assign op_ready  = op_ready_q;
  assign ext_ready = ext_ready_q;

  // ---------------------------------------------------------------------------
  // Data memory: synchronous read and write, contents survive reset.
  // The read address is the captured one, so data read in LD_RD is on
  // mem_rdata_q during LD_WB.
  // ---------------------------------------------------------------------------
  assign mem_we    = rst_n && (state_q == ST_WR);
  // Register array is read before this edge's writes land, so a same-cycle
  // external write to the store's source register does not leak into memory.
  assign mem_wdata = regs_q[oreg_q];

  always_comb begin
    mem_rdata_d = mem_q[maddr_q];
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[maddr_q] <= mem_wdata;
    end
    mem_rdata_q <= mem_rdata_d;
  end

  // ---------------------------------------------------------------------------
  // Register file: combinational read, synchronous write, cleared on reset.
  // ext_ready is low exactly in LD_WB, so the two write sources never collide.
  // ---------------------------------------------------------------------------
  assign ext_acc = ext_we && ext_ready_q;
  assign ld_we   = (state_q == LD_WB);

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (ext_acc) begin
      regs_d[ext_waddr] = ext_wdata;
    end
    if (ld_we) begin
      regs_d[oreg_q] = mem_rdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // No write bypass: a write becomes visible the cycle after its edge.
  assign ra_data = regs_q[ra_addr];
  assign rb_data = regs_q[rb_addr];

endmodule

// File: tb/tb_dmem_reg_ctrl.sv
`timescale 1ns/1ps
module tb_dmem_reg_ctrl;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic          op_kind = 1'b0;
  logic [AW-1:0] op_maddr = '0;
  logic [RW-1:0] op_reg = '0;
  logic          done;
  logic          ext_we = 1'b0;
  logic [RW-1:0] ext_waddr = '0;
  logic [DW-1:0] ext_wdata = '0;
  logic          ext_ready;
  logic [RW-1:0] ra_addr = '0;
  logic [RW-1:0] rb_addr = '0;
  logic [DW-1:0] ra_data;
  logic [DW-1:0] rb_data;

  always #5 clk = ~clk;

  dmem_reg_ctrl #(.DATA_W(DW), .ADDR_W(AW), .REG_AW(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_kind(op_kind),
    .op_maddr(op_maddr), .op_reg(op_reg), .done(done),
    .ext_we(ext_we), .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
    .ext_ready(ext_ready),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard queues: expected done pulses and expected read-port/status values.
  typedef struct {
    int    cyc;
    string name;
  } done_exp_t;

  typedef struct {
    string         name;
    logic [RW-1:0] addr;
    logic [DW-1:0] data;
    bit            chk_rdy;
    logic          op_rdy;
    logic          ext_rdy;
  } rd_exp_t;

  done_exp_t done_exp_q[$];
  rd_exp_t   rd_exp_q[$];
  logic      rd_chk = 1'b0;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    done_exp_t e;
    rd_exp_t   r;
    if (done === 1'b1) begin
      tests++;
      if (done_exp_q.size() == 0) begin
        fails++;
        $display("FAIL done_unexpected: done=1 at cycle %0d, required no pulse", cyc);
      end else begin
        e = done_exp_q.pop_front();
        if (e.cyc != cyc) begin
          fails++;
          $display("FAIL %s: done at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
        end
      end
    end
    if (rd_chk === 1'b1 && rd_exp_q.size() != 0) begin
      r = rd_exp_q.pop_front();
      tests++;
      if (ra_data !== r.data || rb_data !== r.data ||
          (r.chk_rdy && (op_ready !== r.op_rdy || ext_ready !== r.ext_rdy))) begin
        fails++;
        $display("FAIL %s: ra=%h rb=%h op_ready=%b ext_ready=%b, required data=%h op_ready=%b ext_ready=%b",
                 r.name, ra_data, rb_data, op_ready, ext_ready, r.data, r.op_rdy, r.ext_rdy);
      end
    end
  end

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic accept(input bit kind, input string name, output int acc_cyc);
    int        n;
    done_exp_t e;
    n = 0;
    @(negedge clk);
    while (op_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    acc_cyc = cyc;
    if (op_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL %s_accept: op_ready=%b after 20 cycles, required 1", name, op_ready);
    end else begin
      e.cyc  = cyc + (kind ? 1 : 2);
      e.name = name;
      done_exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit kind, input logic [AW-1:0] a, input logic [RW-1:0] r,
                       input string name);
    int c;
    op_valid = 1'b1;
    op_kind  = kind;
    op_maddr = a;
    op_reg   = r;
    accept(kind, name, c);
    op_valid = 1'b0;
  endtask

  task automatic ext_write(input logic [RW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    ext_we    = 1'b1;
    ext_waddr = a;
    ext_wdata = d;
    @(negedge clk);
    while (ext_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (ext_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL ext_write_timeout: ext_ready=%b, required 1", ext_ready);
    end
    @(posedge clk);
    #1;
    ext_we = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (op_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (op_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: op_ready=%b, required 1", op_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [RW-1:0] a, input logic [DW-1:0] d,
                     input bit crdy, input logic opr, input logic exr);
    rd_exp_t r;
    r.name = name; r.addr = a; r.data = d;
    r.chk_rdy = crdy; r.op_rdy = opr; r.ext_rdy = exr;
    rd_exp_q.push_back(r);
    ra_addr = a;
    rb_addr = a;
    rd_chk  = 1'b1;
    @(posedge clk);
    #1;
    rd_chk = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc[3];
    int c;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_state", 5'd0, 16'h0000, 1'b1, 1'b1, 1'b1);
    chk("rst_r31", 5'd31, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Ext write, store, back-to-back load
    ext_write(5'd3, 16'h1234);
    issue(1'b1, 8'h10, 5'd3, "st_r3_m10");
    issue(1'b0, 8'h10, 5'd7, "ld_m10_r7");
    wait_idle();
    chk("r7_loaded", 5'd7, 16'h1234, 1'b1, 1'b1, 1'b1);

    // Ext write blocked during LD_WB, held request lands next cycle
    issue(1'b0, 8'h10, 5'd5, "ld_m10_r5");
    @(posedge clk);
    #1;
    ext_we    = 1'b1;
    ext_waddr = 5'd9;
    ext_wdata = 16'h9999;
    chk("ldwb_ext_blocked", 5'd9, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("ext_held_idle", 5'd9, 16'h0000, 1'b1, 1'b1, 1'b1);
    ext_we = 1'b0;
    chk("r9_written", 5'd9, 16'h9999, 1'b0, 1'b0, 1'b0);
    chk("r5_loaded", 5'd5, 16'h1234, 1'b0, 1'b0, 1'b0);

    // Store sees pre-write value of a same-cycle ext write
    ext_write(5'd2, 16'h00AA);
    issue(1'b1, 8'h20, 5'd2, "st_r2_m20");
    ext_we    = 1'b1;
    ext_waddr = 5'd2;
    ext_wdata = 16'h5555;
    chk("st_wr_old_r2", 5'd2, 16'h00AA, 1'b1, 1'b0, 1'b1);
    ext_we = 1'b0;
    chk("r2_new", 5'd2, 16'h5555, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 8'h20, 5'd8, "ld_m20_r8");
    wait_idle();
    chk("mem20_old", 5'd8, 16'h00AA, 1'b0, 1'b0, 1'b0);

    // Address extremes do not alias
    ext_write(5'd10, 16'hBEEF);
    ext_write(5'd11, 16'h0001);
    issue(1'b1, 8'hFF, 5'd10, "st_mff");
    issue(1'b1, 8'h00, 5'd11, "st_m00");
    issue(1'b0, 8'hFF, 5'd12, "ld_mff");
    issue(1'b0, 8'h00, 5'd13, "ld_m00");
    issue(1'b0, 8'h10, 5'd14, "ld_m10_r14");
    wait_idle();
    chk("mff_beef", 5'd12, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    chk("m00_0001", 5'd13, 16'h0001, 1'b0, 1'b0, 1'b0);
    chk("m10_kept", 5'd14, 16'h1234, 1'b0, 1'b0, 1'b0);

    // Reset during LD_WB aborts the load; accepts and ext writes ignored in reset
    issue(1'b0, 8'h10, 5'd4, "ld_abort");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    void'(done_exp_q.pop_back());
    ext_we    = 1'b1;
    ext_waddr = 5'd6;
    ext_wdata = 16'h4444;
    op_valid  = 1'b1;
    op_kind   = 1'b1;
    op_maddr  = 8'h40;
    op_reg    = 5'd4;
    @(posedge clk);
    #1;
    ext_we   = 1'b0;
    op_valid = 1'b0;
    rst_n    = 1'b1;
    chk("rst_abort_r4", 5'd4, 16'h0000, 1'b1, 1'b1, 1'b1);
    chk("rst_ext_ignored", 5'd6, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("rst_clears_r7", 5'd7, 16'h0000, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 8'h10, 5'd1, "ld_after_rst");
    wait_idle();
    chk("mem_survives_rst", 5'd1, 16'h1234, 1'b0, 1'b0, 1'b0);

    // op_valid held for three stores: accept every 2 cycles
    ext_write(5'd15, 16'hA5A5);
    ext_write(5'd16, 16'h5A5A);
    ext_write(5'd17, 16'h0F0F);
    op_valid = 1'b1;
    op_kind  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op_maddr = 8'(8'h30 + i);
      op_reg   = 5'(15 + i);
      accept(1'b1, "held_store", acc[i]);
    end
    op_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      tests++;
      if (acc[i] - acc[i-1] != 2) begin
        fails++;
        $display("FAIL held_accept_gap: gap %0d cycles, required 2", acc[i] - acc[i-1]);
      end
    end
    issue(1'b0, 8'h30, 5'd20, "ld_m30");
    issue(1'b0, 8'h31, 5'd21, "ld_m31");
    issue(1'b0, 8'h32, 5'd22, "ld_m32");
    wait_idle();
    chk("m30", 5'd20, 16'hA5A5, 1'b0, 1'b0, 1'b0);
    chk("m31", 5'd21, 16'h5A5A, 1'b0, 1'b0, 1'b0);
    chk("m32", 5'd22, 16'h0F0F, 1'b1, 1'b1, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    c = done_exp_q.size();
    tests++;
    if (c != 0) begin
      fails++;
      $display("FAIL done_missing: %0d pulses outstanding, required 0", c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
